// File: rtl/vec_stream_reader.sv
// Vector stream producer: reads cmd_len consecutive words from a 1-cycle SRAM
// starting at cmd_addr and streams them out through a 2-entry FIFO.
module vec_stream_reader #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;
  logic [1:0][DATA_W-1:0]   mem_q, mem_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               cnt_q, cnt_d;

  logic                     push, pop, issue, cmd_fire;
  logic [2:0]               occ;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign cmd_ready = (state_q == IDLE);
  assign sram_en   = issue;
  assign sram_addr = addr_q;
  assign done      = done_q;

  always_comb begin
    push     = inflight_q;
    pop      = out_valid & out_ready;
    cmd_fire = cmd_valid & cmd_ready;
    // Credit: a word is only requested if a FIFO slot is certain to be free
    // when its data lands, counting the pop happening this cycle.
    occ      = {1'b0, cnt_q} + {2'b0, inflight_q};
    issue    = (state_q == READ) && (occ < (3'd2 + {2'b0, pop}));

    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    inflight_d = issue;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish when the FIFO empties this cycle, so done lands with cmd_ready.
        if (!inflight_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = sram_rdata;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
